// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined block carry-lookahead adder/subtractor, one BLOCK-bit group per stage
// Valid/ready on both sides; the last stage register drives the outputs directly.

module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / BLOCK;

  if ((BLOCK < 1) || ((WIDTH % BLOCK) != 0)) begin : g_width_check
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Returns {carry into group MSB, group carry out, group sum bits}.
  function automatic logic [BLOCK+1:0] grp_add(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             term;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= BLOCK; i++) begin
      term = ci;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [NGRP-1:0]            vld_q;
  logic [NGRP-1:0][WIDTH-1:0] a_q, a_d;
  logic [NGRP-1:0][WIDTH-1:0] bm_q, bm_d;
  logic [NGRP-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [NGRP-1:0]            c_q, c_d;
  logic [NGRP-1:0]            ovf_q, ovf_d;

  logic [NGRP-1:0]            src_vld;
  logic [NGRP-1:0][WIDTH-1:0] src_a, src_bm, src_sum;
  logic [NGRP-1:0]            src_c;
  logic [NGRP-1:0]            rdy;
  logic [BLOCK+1:0]           grp_res;

  always_comb begin
    src_vld    = '0;
    src_a      = '0;
    src_bm     = '0;
    src_sum    = '0;
    src_c      = '0;
    a_d        = '0;
    bm_d       = '0;
    sum_d      = '0;
    c_d        = '0;
    ovf_d      = '0;
    rdy        = '0;
    grp_res    = '0;

    // Subtraction is folded into the operand: b' = ~b with carry-in forced to 1.
    src_vld[0] = in_valid;
    src_a[0]   = a;
    src_bm[0]  = sub ? ~b : b;
    src_sum[0] = '0;
    src_c[0]   = sub ? 1'b1 : cin;
    for (int k = 1; k < NGRP; k++) begin
      src_vld[k] = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_bm[k]  = bm_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_c[k]   = c_q[k-1];
    end

    for (int k = 0; k < NGRP; k++) begin
      grp_res  = grp_add(src_a[k][k*BLOCK +: BLOCK], src_bm[k][k*BLOCK +: BLOCK], src_c[k]);
      a_d[k]   = src_a[k];
      bm_d[k]  = src_bm[k];
      sum_d[k] = src_sum[k];
      sum_d[k][k*BLOCK +: BLOCK] = grp_res[BLOCK-1:0];
      c_d[k]   = grp_res[BLOCK];
      ovf_d[k] = grp_res[BLOCK+1] ^ grp_res[BLOCK];
    end

    rdy[NGRP-1] = !vld_q[NGRP-1] || out_ready;
    for (int k = NGRP - 2; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      bm_q  <= '0;
      sum_q <= '0;
      c_q   <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NGRP; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= src_vld[k];
          // Data only moves with a token so a stalled or drained output stays put.
          if (src_vld[k]) begin
            a_q[k]   <= a_d[k];
            bm_q[k]  <= bm_d[k];
            sum_q[k] <= sum_d[k];
            c_q[k]   <= c_d[k];
            ovf_q[k] <= ovf_d[k];
          end
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{a_q, bm_q, ovf_q};

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[NGRP-1];
  assign sum       = sum_q[NGRP-1];
  assign cout      = c_q[NGRP-1];
  assign ovf       = ovf_q[NGRP-1];

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - randomized and directed checks of cla_adder_pipe against a signed-arithmetic model
// Scoreboard queue is filled at input transfer and drained at output transfer.

module tb_cla_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
    bit          lat;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nres = 0;
  int   nexp = 0;
  bit   prev_stall = 0;
  logic [15:0] prev_sum;
  logic        prev_cout, prev_ovf;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    exp_t r;
    int sa, sb, sres, ures;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      sres   = sa - sb;
      r.cout = (ma >= mb);
    end else begin
      sres   = sa + sb + int'(mcin);
      ures   = int'(ma) + int'(mb) + int'(mcin);
      r.cout = (ures > 65535);
    end
    ures  = sres;
    r.sum = ures[15:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    r.due = 0;
    r.lat = 0;
    return r;
  endfunction

  // Called at posedge+1; returns at the posedge+1 after the op is accepted.
  task automatic push_op(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic tcin, input logic tsub, input bit lat);
    exp_t e;
    int n;
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e = model(ta, tbv, tcin, tsub);
      e.due = cyc + 4;
      e.lat = lat;
      q.push_back(e);
      nexp++;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(tag, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, prev_sum);
        check("hold_cout", cout, prev_cout);
        check("hold_ovf", ovf, prev_ovf);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ovf   = ovf;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e_mon = q.pop_front();
          check("sum", sum, e_mon.sum);
          check("cout", cout, e_mon.cout);
          check("ovf", ovf, e_mon.ovf);
          if (e_mon.lat) check("latency", cyc, e_mon.due);
          nres++;
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    push_op(16'hFFFF, 16'h0001, 0, 0, 1);
    drain("drain_wrap");
    push_op(16'h7FFF, 16'h0001, 0, 0, 1);
    push_op(16'h8000, 16'h0001, 0, 1, 1);
    push_op(16'h0005, 16'h0007, 1, 1, 1);
    push_op(16'h0000, 16'h0000, 1, 0, 1);
    push_op(16'h8000, 16'h8000, 0, 0, 1);
    drain("drain_directed");

    for (int i = 0; i < 100; i++) begin
      check("stream_in_ready", in_ready, 1);
      push_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
    end
    drain("drain_stream");

    out_ready = 0;
    for (int i = 0; i < 4; i++) push_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
    a = 16'h4321; b = 16'h0FED; cin = 1; sub = 0; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    push_op(16'h4321, 16'h0FED, 1, 0, 0);
    drain("drain_bp");

    push_op(16'h1111, 16'h2222, 0, 0, 0);
    push_op(16'hAAAA, 16'h5555, 1, 0, 0);
    push_op(16'h0F0F, 16'h00F0, 0, 1, 0);
    rst = 1;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    nexp = nexp - q.size();
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    push_op(16'h1234, 16'h1111, 0, 0, 1);
    drain("drain_after_rst");

    repeat (10) @(posedge clk);
    check("result_count", nres, nexp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
